// File: rtl/inst_report_pkg.sv
// Shared definitions for the leaf-report collector: default sizes,
// counter widths, the report record and a round-robin helper.
package inst_report_pkg;

    localparam int DEF_NLEAF = 16;
    localparam int DEF_VW    = 32;
    localparam int DEF_IDW   = 5;
    localparam int DEF_DEPTH = 4;
    localparam int SEQ_W     = 8;
    localparam int ACC_W     = 16;

    // Report record at the default sizes; the collector builds an equivalent
    // record from its own parameters.
    typedef struct packed {
        logic [DEF_IDW-1:0] id;
        logic [DEF_VW-1:0]  value;
        logic [SEQ_W-1:0]   seq;
    } report_t;

    // Index following k in a ring of n slots.
    function automatic int rr_next(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/report_fifo.sv
// Small synchronous FIFO whose head entry lives in a dedicated output
// register, so the consumer always sees a registered value and the last
// popped entry stays visible once the FIFO drains. Entries behind the head
// sit in a RAM-style ring without reset.
module report_fifo
    import inst_report_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_head;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_head_from_din;
    logic w_head_from_mem;
    logic w_mem_wr;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_dout    = r_head;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // The incoming entry goes straight to the head register when it will be
    // the only entry; otherwise it queues in the ring behind the head.
    assign w_head_from_din = w_push_ok && (o_empty || (r_count == (AW+1)'(1) && w_pop_ok));
    assign w_head_from_mem = w_pop_ok && (r_count > (AW+1)'(1));
    assign w_mem_wr        = w_push_ok && !w_head_from_din;

    // Ring storage write port (no reset, pointers define validity).
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Head register, ring pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_head_from_mem) begin
                r_head   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else if (w_head_from_din) begin
                r_head <= i_din;
            end
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/inst_report_collector.sv
// Collects one report per leaf instance: round-robin grant among requesting
// leaves, queues accepted reports in report_fifo and streams them out under
// valid/ready. Also tracks a sequence number, a running checksum and an
// acceptance count so a checker can verify completeness.
module inst_report_collector
    import inst_report_pkg::*;
#(
    parameter int NLEAF = DEF_NLEAF,
    parameter int VW    = DEF_VW,
    parameter int IDW   = DEF_IDW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NLEAF-1:0]    i_req_valid,
    input  logic [NLEAF*VW-1:0] i_req_value,
    output logic [NLEAF-1:0]    o_req_ready,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [IDW-1:0]      o_out_id,
    output logic [VW-1:0]       o_out_value,
    output logic [SEQ_W-1:0]    o_out_seq,
    output logic [VW-1:0]       o_checksum,
    output logic [ACC_W-1:0]    o_accepted
);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [VW-1:0]    value;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    localparam int EW = IDW + VW + SEQ_W;
    localparam logic [IDW:0] LIM = (IDW+1)'(NLEAF);

    logic [IDW-1:0]   r_ptr;
    logic [SEQ_W-1:0] r_seq;
    logic [VW-1:0]    r_checksum;
    logic [ACC_W-1:0] r_accepted;

    logic [IDW-1:0]   w_rot_idx [NLEAF];
    logic [NLEAF-1:0] w_rot_valid;
    logic             w_found;
    logic [IDW-1:0]   w_grant_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_can_push;
    logic             w_xfer;
    logic [VW-1:0]    w_value;
    entry_t           w_push_entry;
    entry_t           w_head;

    // Scan order starting at the round-robin pointer: slot gi looks at leaf
    // (ptr + gi) mod NLEAF.
    generate
        for (genvar gi = 0; gi < NLEAF; gi++) begin : g_rot
            logic [IDW:0] w_sum;
            assign w_sum          = {1'b0, r_ptr} + (IDW+1)'(gi);
            assign w_rot_idx[gi]  = (w_sum >= LIM) ? IDW'(w_sum - LIM) : IDW'(w_sum);
            assign w_rot_valid[gi] = i_req_valid[w_rot_idx[gi]];
        end
    endgenerate

    // Pick the first requesting leaf in scan order (lowest slot wins).
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = NLEAF - 1; i >= 0; i--) begin
            if (w_rot_valid[i]) begin
                w_found     = 1'b1;
                w_grant_idx = w_rot_idx[i];
            end
        end
    end

    assign w_pop      = o_out_valid && i_out_ready;
    assign w_can_push = !w_full || w_pop;
    assign w_xfer     = rst_n && w_can_push && w_found;
    assign w_value    = i_req_value[int'(w_grant_idx)*VW +: VW];

    // One-hot grant; held low while reset is asserted.
    generate
        for (genvar gi = 0; gi < NLEAF; gi++) begin : g_grant
            assign o_req_ready[gi] = w_xfer && (w_grant_idx == IDW'(gi));
        end
    endgenerate

    // Round-robin pointer, sequence number, checksum and count advance on
    // every accepted report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_seq      <= '0;
            r_checksum <= '0;
            r_accepted <= '0;
        end else if (w_xfer) begin
            r_ptr      <= IDW'(rr_next(int'(w_grant_idx), NLEAF));
            r_seq      <= r_seq + SEQ_W'(1);
            r_checksum <= r_checksum + w_value;
            r_accepted <= r_accepted + ACC_W'(1);
        end
    end

    assign w_push_entry = '{id: w_grant_idx, value: w_value, seq: r_seq};

    report_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_xfer),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_out_valid = !w_empty;
    assign o_out_id    = w_head.id;
    assign o_out_value = w_head.value;
    assign o_out_seq   = w_head.seq;
    assign o_checksum  = r_checksum;
    assign o_accepted  = r_accepted;

endmodule

// File: tb/tb_inst_report_collector.sv
// Randomized and directed bench for inst_report_collector with a queue-based
// reference model of grants, FIFO contents and counters.
module tb_inst_report_collector;
    import inst_report_pkg::*;

    localparam int NLEAF = 16;
    localparam int VW    = 32;
    localparam int IDW   = 5;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NLEAF-1:0]    req_valid = '0;
    logic [NLEAF*VW-1:0] req_value = '0;
    logic [NLEAF-1:0]    req_ready;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [IDW-1:0]      out_id;
    logic [VW-1:0]       out_value;
    logic [7:0]          out_seq;
    logic [VW-1:0]       checksum;
    logic [15:0]         accepted;

    always #5 clk = ~clk;

    inst_report_collector #(
        .NLEAF (NLEAF),
        .VW    (VW),
        .IDW   (IDW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_value (req_value),
        .o_req_ready (req_ready),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_id    (out_id),
        .o_out_value (out_value),
        .o_out_seq   (out_seq),
        .o_checksum  (checksum),
        .o_accepted  (accepted)
    );

    // Reference model state
    report_t          q[$];
    report_t          m_last = '0;
    int               m_ptr = 0;
    logic [7:0]       m_seq = '0;
    logic [VW-1:0]    m_cks = '0;
    logic [15:0]      m_acc = '0;
    logic [NLEAF-1:0] m_last_grant = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected grant: first requesting leaf walking from the pointer, if room.
    function automatic logic [NLEAF-1:0] exp_grant();
        logic [NLEAF-1:0] g;
        g = '0;
        if (rst_n && (q.size() < DEPTH || (q.size() > 0 && out_ready))) begin
            for (int i = 0; i < NLEAF; i++) begin
                int k;
                k = (m_ptr + i) % NLEAF;
                if (g == '0 && req_valid[k]) g[k] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic report_t exp_head();
        return (q.size() > 0) ? q[0] : m_last;
    endfunction

    // Apply what the coming clock edge does to the model.
    task automatic model_edge();
        logic [NLEAF-1:0] g;
        report_t e;
        g = exp_grant();
        m_last_grant = g;
        if (!rst_n) begin
            q.delete();
            m_ptr = 0; m_seq = '0; m_cks = '0; m_acc = '0;
            m_last = '0; m_last_grant = '0;
            return;
        end
        if (q.size() > 0 && out_ready) begin
            m_last = q.pop_front();
            $display("pop id=%0d value=%h seq=%0d", m_last.id, m_last.value, m_last.seq);
        end
        for (int k = 0; k < NLEAF; k++) begin
            if (g[k]) begin
                e.id    = IDW'(k);
                e.value = req_value[k*VW +: VW];
                e.seq   = m_seq;
                q.push_back(e);
                m_seq = m_seq + 8'd1;
                m_cks = m_cks + e.value;
                m_acc = m_acc + 16'd1;
                m_ptr = (k + 1) % NLEAF;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int k, input logic [VW-1:0] v);
        req_value[k*VW +: VW] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; out_ready = 1'b1;
        for (int k = 0; k < NLEAF; k++) set_val(k, $urandom);
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== '0) $display("FAIL reset_ready: got %h want 0", req_ready); else n_pass++;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
            n_checks++; if (checksum !== '0) $display("FAIL reset_checksum: got %h want 0", checksum); else n_pass++;
            n_checks++; if (accepted !== '0) $display("FAIL reset_accepted: got %h want 0", accepted); else n_pass++;
            tick();
        end
    endtask

    task automatic test_single();
        logic [IDW+VW+7:0] want;
        rst_n = 1'b1; req_valid = '0; out_ready = 1'b1;
        tick();
        req_valid = 16'h0020; set_val(5, 32'h2A);
        @(negedge clk);
        n_checks++; if (req_ready !== 16'h0020) $display("FAIL single_grant: got %h want 0020", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        @(negedge clk);
        want = {5'd5, 32'h2A, 8'd0};
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
        n_checks++; if ({out_id, out_value, out_seq} !== want) $display("FAIL single_head: got %h want %h", {out_id, out_value, out_seq}, want); else n_pass++;
        n_checks++; if (checksum !== 32'h2A) $display("FAIL single_checksum: got %h want 2a", checksum); else n_pass++;
        n_checks++; if (req_ready !== '0) $display("FAIL single_no_regrant: got %h want 0", req_ready); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drained: got %b want 0", out_valid); else n_pass++;
        tick();
    endtask

    task automatic test_fairness();
        logic [IDW+VW+7:0] want;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req_valid = '1; out_ready = 1'b1;
        for (int k = 0; k < NLEAF; k++) set_val(k, 32'(2*k + 1));
        for (int c = 0; c <= NLEAF; c++) begin
            @(negedge clk);
            if (c < NLEAF) begin
                n_checks++; if (req_ready !== (16'(1) << c)) $display("FAIL fair_grant c=%0d: got %h want %h", c, req_ready, 16'(1) << c); else n_pass++;
            end
            if (c > 0) begin
                want = {5'(c-1), 32'(2*(c-1) + 1), 8'(c-1)};
                n_checks++; if (!out_valid || {out_id, out_value, out_seq} !== want) $display("FAIL fair_out c=%0d: got v=%b %h want %h", c, out_valid, {out_id, out_value, out_seq}, want); else n_pass++;
            end
            tick();
            if (c < NLEAF) req_valid[c] = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (checksum !== 32'd256) $display("FAIL fair_checksum: got %0d want 256", checksum); else n_pass++;
        n_checks++; if (accepted !== 16'd16) $display("FAIL fair_accepted: got %0d want 16", accepted); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [NLEAF-1:0] want_g;
        report_t h;
        out_ready = 1'b0; req_valid = '1;
        for (int k = 0; k < NLEAF; k++) set_val(k, $urandom);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            want_g = (c < 4) ? (16'(1) << c) : '0;
            n_checks++; if (req_ready !== want_g) $display("FAIL bp_grant c=%0d: got %h want %h", c, req_ready, want_g); else n_pass++;
            if (c > 0) begin
                n_checks++; if (out_valid !== 1'b1 || out_id !== 5'd0) $display("FAIL bp_frozen c=%0d: got v=%b id=%0d want v=1 id=0", c, out_valid, out_id); else n_pass++;
            end
            tick();
            if (c < 4) req_valid[c] = 1'b0;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            h = exp_head();
            n_checks++; if (req_ready !== (16'(1) << (4 + c))) $display("FAIL bp_release_grant c=%0d: got %h want %h", c, req_ready, 16'(1) << (4 + c)); else n_pass++;
            n_checks++; if ({out_id, out_value, out_seq} !== h) $display("FAIL bp_release_head c=%0d: got %h want %h", c, {out_id, out_value, out_seq}, h); else n_pass++;
            tick();
            req_valid[4 + c] = 1'b0;
        end
        // FIFO is full here; pop and push in the same cycle
        req_valid = 16'h0080;
        @(negedge clk);
        n_checks++; if (req_ready !== 16'h0080) $display("FAIL full_pop_grant: got %h want 0080", req_ready); else n_pass++;
        tick();
        out_ready = 1'b0; req_valid = 16'h0100;
        @(negedge clk);
        n_checks++; if (req_ready !== '0 || out_valid !== 1'b1) $display("FAIL full_still_full: got ready=%h v=%b want 0/1", req_ready, out_valid); else n_pass++;
        tick();
        out_ready = 1'b1; req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            h = exp_head();
            n_checks++; if (out_valid !== (q.size() > 0) || {out_id, out_value, out_seq} !== h) $display("FAIL drain c=%0d: got v=%b %h want %h", c, out_valid, {out_id, out_value, out_seq}, h); else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [NLEAF-1:0] g;
        report_t h;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            g = exp_grant();
            h = exp_head();
            n_checks++; if (req_ready !== g) $display("FAIL rnd_grant c=%0d: got %h want %h", c, req_ready, g); else n_pass++;
            n_checks++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, q.size() > 0); else n_pass++;
            n_checks++; if ({out_id, out_value, out_seq} !== h) $display("FAIL rnd_head c=%0d: got %h want %h", c, {out_id, out_value, out_seq}, h); else n_pass++;
            n_checks++; if (checksum !== m_cks || accepted !== m_acc) $display("FAIL rnd_counters c=%0d: got %h/%0d want %h/%0d", c, checksum, accepted, m_cks, m_acc); else n_pass++;
            tick();
            for (int k = 0; k < NLEAF; k++) begin
                if (m_last_grant[k]) req_valid[k] = 1'b0;
                else if (req_valid[k] && $urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
                if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
                    req_valid[k] = 1'b1;
                    set_val(k, $urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] seqs [4];
        logic [7:0] want_seq [4];
        int grants, pops;
        report_t h;
        want_seq = '{8'd254, 8'd255, 8'd0, 8'd1};
        seqs = '{8'hxx, 8'hxx, 8'hxx, 8'hxx};
        grants = 0; pops = 0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        out_ready = 1'b1; req_valid = '1;
        for (int k = 0; k < NLEAF; k++) set_val(k, $urandom);
        for (int c = 0; c < 266; c++) begin
            @(negedge clk);
            h = exp_head();
            n_checks++; if (out_valid !== (q.size() > 0) || {out_id, out_value, out_seq} !== h) $display("FAIL wrap_head c=%0d: got v=%b %h want %h", c, out_valid, {out_id, out_value, out_seq}, h); else n_pass++;
            if (out_valid === 1'b1) begin
                if (pops >= 254 && pops < 258) seqs[pops - 254] = out_seq;
                pops++;
            end
            tick();
            grants += $countones(m_last_grant);
            for (int k = 0; k < NLEAF; k++) if (m_last_grant[k]) set_val(k, $urandom);
            if (grants >= 258) req_valid = '0;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (seqs[i] !== want_seq[i]) $display("FAIL wrap_seq %0d: got %0d want %0d", i, seqs[i], want_seq[i]); else n_pass++;
        end
        n_checks++; if (accepted !== 16'd258) $display("FAIL wrap_accepted: got %0d want 258", accepted); else n_pass++;
        // queue three entries, then reset mid-run
        out_ready = 1'b0; req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== exp_grant()) $display("FAIL mid_fill c=%0d: got %h want %h", c, req_ready, exp_grant()); else n_pass++;
            tick();
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== '0) $display("FAIL mid_reset_ready: got %h want 0", req_ready); else n_pass++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (accepted !== '0) $display("FAIL mid_reset_accepted: got %0d want 0", accepted); else n_pass++;
        n_checks++; if (req_ready !== 16'h0001) $display("FAIL mid_reset_ptr: got %h want 0001", req_ready); else n_pass++;
        tick();
        out_ready = 1'b1; req_valid = '0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_random();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
